serial_to_parallel_rx: RTL

//  Receive end of the team's framed parallel-to-serial link: samples a serial line on bit-rate ticks,

---
 rtl/serial_to_parallel_rx_pkg.sv | 21 ++
 rtl/serial_to_parallel_rx_sipo_shift_reg.sv | 27 ++
 rtl/serial_to_parallel_rx.sv | 112 +++++++++++
 3 files changed

// File: rtl/serial_to_parallel_rx_pkg.sv
// Shared framing definitions for the serial link: receiver FSM states and line levels.
// Also used by the transmitter side, so encodings must stay fixed at 2 bits.
package serial_to_parallel_rx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        STOP  = 2'd2,
        BREAK = 2'd3
    } rx_state_t;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

    // Bit-counter width; a 1-bit frame still needs a 1-bit counter.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_to_parallel_rx_sipo_shift_reg.sv
// Shift-right assembly register: new bit enters at the MSB, so after N shifts
// the first (LSB-first) bit on the line sits in bit 0.
module sipo_shift_reg #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         din,
    output logic [N-1:0] dout
);

    generate
        if (N == 1) begin : g_single
            always_ff @(posedge clk or negedge reset) begin
                if (!reset)  dout <= '0;
                else if (en) dout <= din;
            end
        end else begin : g_multi
            always_ff @(posedge clk or negedge reset) begin
                if (!reset)  dout <= '0;
                else if (en) dout <= {din, dout[N-1:1]};
            end
        end
    endgenerate

endmodule

// File: rtl/serial_to_parallel_rx.sv
// Framed serial receiver: start bit 0, N data bits LSB first, stop bit 1, one bit per tick.
// Outputs are registered; par_valid/frame_err pulse one clk after the stop-bit tick.
module serial_to_parallel_rx
    import serial_to_parallel_rx_pkg::*;
#(
    parameter int N     = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             ser_in,
    output logic [N-1:0]     par_out,
    output logic             par_valid,
    output logic             frame_err,
    output logic             busy,
    output logic [CNT_W-1:0] rx_count
);

    localparam int              CW   = cnt_width(N);
    localparam logic [CW-1:0]   LAST = CW'(N - 1);

    rx_state_t      state;
    rx_state_t      next_state;
    logic [CW-1:0]  bit_cnt;
    logic           sync_q1;
    logic           ser_s;
    logic [N-1:0]   shift_q;
    logic           shift_en;
    logic           cnt_clr;
    logic           good_stop;
    logic           bad_stop;

    // ser_in is asynchronous to clk; resetting to the idle level avoids a false start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q1 <= IDLE_LEVEL;
            ser_s   <= IDLE_LEVEL;
        end else begin
            sync_q1 <= ser_in;
            ser_s   <= sync_q1;
        end
    end

    always_comb begin
        next_state = state;
        shift_en   = 1'b0;
        cnt_clr    = 1'b0;
        good_stop  = 1'b0;
        bad_stop   = 1'b0;
        if (tick) begin
            case (state)
                IDLE: begin
                    if (ser_s == START_BIT) begin
                        next_state = DATA;
                        cnt_clr    = 1'b1;
                    end
                end
                DATA: begin
                    shift_en = 1'b1;
                    if (bit_cnt == LAST) next_state = STOP;
                end
                STOP: begin
                    if (ser_s == STOP_BIT) begin
                        good_stop  = 1'b1;
                        next_state = IDLE;
                    end else begin
                        bad_stop   = 1'b1;
                        next_state = BREAK;
                    end
                end
                BREAK: begin
                    // A line stuck low must not be mistaken for a new start bit.
                    if (ser_s == IDLE_LEVEL) next_state = IDLE;
                end
                default: next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            bit_cnt   <= '0;
            par_out   <= '0;
            par_valid <= 1'b0;
            frame_err <= 1'b0;
            rx_count  <= '0;
        end else begin
            state     <= next_state;
            busy      <= (next_state != IDLE);
            par_valid <= good_stop;
            frame_err <= bad_stop;
            if (cnt_clr)       bit_cnt <= '0;
            else if (shift_en) bit_cnt <= bit_cnt + 1'b1;
            if (good_stop) begin
                par_out  <= shift_q;
                rx_count <= rx_count + 1'b1;
            end
        end
    end

    sipo_shift_reg #(.N(N)) u_sipo (
        .clk   (clk),
        .reset (reset),
        .en    (shift_en),
        .din   (ser_s),
        .dout  (shift_q)
    );

endmodule
